// File: rtl/ucie_ctl_param_negotiator.sv
// Adapter parameter negotiation: advertise local caps over sideband, capture the remote
// SB_ADV_CAP_ADAPTER payload, evaluate compatibility and report done/fail to the CNTL FSM.
module ucie_ctl_param_negotiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_clear,
    input  logic [2:0]  i_local_protocol,
    input  logic [3:0]  i_local_format,
    output logic        o_sb_tx_valid,
    output logic [4:0]  o_sb_tx_msg,
    output logic [15:0] o_sb_tx_data,
    input  logic        i_sb_tx_ready,
    input  logic        i_sb_rx_valid,
    input  logic [4:0]  i_sb_rx_msg,
    input  logic [15:0] i_sb_rx_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fail,
    output logic [2:0]  o_neg_protocol,
    output logic [3:0]  o_neg_format
);

    localparam logic [4:0] SB_ADV_CAP_ADAPTER = 5'b00000;
    localparam logic [3:0] RAW_FORMAT         = 4'b0001;

    typedef enum logic [2:0] {
        IDLE, SEND_CAP, WAIT_CAP, EVAL, DONE, FAIL
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cap_vld_q, cap_vld_d;
    logic [2:0]         rem_proto_q, rem_proto_d, loc_proto_q, loc_proto_d;
    logic [3:0]         rem_fmt_q, rem_fmt_d, loc_fmt_q, loc_fmt_d;
    logic               tx_valid_q, tx_valid_d;
    logic [6:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic [2:0]         neg_proto_q, neg_proto_d;
    logic [3:0]         neg_fmt_q, neg_fmt_d;

    logic rx_cap, have_cap, eval_ok;
    logic rx_data_unused;

    assign rx_data_unused = ^i_sb_rx_data[15:7];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_vld_d   = cap_vld_q;
        rem_proto_d = rem_proto_q;
        rem_fmt_d   = rem_fmt_q;
        loc_proto_d = loc_proto_q;
        loc_fmt_d   = loc_fmt_q;
        neg_proto_d = neg_proto_q;
        neg_fmt_d   = neg_fmt_q;

        rx_cap = i_sb_rx_valid && (i_sb_rx_msg == SB_ADV_CAP_ADAPTER) &&
                 ((state_q == SEND_CAP) || (state_q == WAIT_CAP));
        // A cap arriving this cycle counts as present, so it beats the timeout.
        have_cap = cap_vld_q || rx_cap;
        if (rx_cap && !cap_vld_q) begin
            cap_vld_d   = 1'b1;
            rem_proto_d = i_sb_rx_data[2:0];
            rem_fmt_d   = i_sb_rx_data[6:3];
        end

        eval_ok = (rem_proto_q == loc_proto_q) &&
                  (loc_proto_q inside {3'b111, 3'b000, 3'b011}) &&
                  (loc_fmt_q == RAW_FORMAT) && (rem_fmt_q == RAW_FORMAT);

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d     = SEND_CAP;
                    loc_proto_d = i_local_protocol;
                    loc_fmt_d   = i_local_format;
                end
            end
            SEND_CAP: begin
                if (i_sb_tx_ready) begin
                    state_d = have_cap ? EVAL : WAIT_CAP;
                    cnt_d   = '0;
                end
            end
            WAIT_CAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (have_cap) begin
                    state_d = EVAL;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = FAIL;
                end
            end
            EVAL: begin
                if (eval_ok) begin
                    state_d     = DONE;
                    neg_proto_d = loc_proto_q;
                    neg_fmt_d   = loc_fmt_q;
                end else begin
                    state_d     = FAIL;
                    neg_proto_d = '0;
                    neg_fmt_d   = '0;
                end
            end
            DONE, FAIL: begin
                if (i_clear) begin
                    state_d     = IDLE;
                    cap_vld_d   = 1'b0;
                    neg_proto_d = '0;
                    neg_fmt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        tx_valid_d = (state_d == SEND_CAP);
        tx_data_d  = (state_d == SEND_CAP) ? {loc_fmt_d, loc_proto_d} : '0;
        busy_d     = (state_d == SEND_CAP) || (state_d == WAIT_CAP) || (state_d == EVAL);
        done_d     = (state_d == DONE);
        fail_d     = (state_d == FAIL);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_vld_q   <= 1'b0;
            rem_proto_q <= '0;
            rem_fmt_q   <= '0;
            loc_proto_q <= '0;
            loc_fmt_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            neg_proto_q <= '0;
            neg_fmt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_vld_q   <= cap_vld_d;
            rem_proto_q <= rem_proto_d;
            rem_fmt_q   <= rem_fmt_d;
            loc_proto_q <= loc_proto_d;
            loc_fmt_q   <= loc_fmt_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            neg_proto_q <= neg_proto_d;
            neg_fmt_q   <= neg_fmt_d;
        end
    end

    assign o_sb_tx_valid  = tx_valid_q;
    assign o_sb_tx_msg    = SB_ADV_CAP_ADAPTER;
    assign o_sb_tx_data   = {9'b0, tx_data_q};
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_fail         = fail_q;
    assign o_neg_protocol = neg_proto_q;
    assign o_neg_format   = neg_fmt_q;

endmodule

// File: tb/tb_ucie_ctl_param_negotiator.sv
// Bench for ucie_ctl_param_negotiator: directed scenarios with literal expectations, then
// random traffic, all compared every cycle against a flag-based behavioural model.
module tb_ucie_ctl_param_negotiator;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst, start, clear, ready, rx_valid;
    logic [2:0]  lproto;
    logic [3:0]  lfmt;
    logic [4:0]  rx_msg;
    logic [15:0] rx_data;
    logic        tx_valid, busy, done, fail;
    logic [4:0]  tx_msg;
    logic [15:0] tx_data;
    logic [2:0]  neg_proto;
    logic [3:0]  neg_fmt;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    ucie_ctl_param_negotiator #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_clear(clear),
        .i_local_protocol(lproto), .i_local_format(lfmt),
        .o_sb_tx_valid(tx_valid), .o_sb_tx_msg(tx_msg), .o_sb_tx_data(tx_data),
        .i_sb_tx_ready(ready), .i_sb_rx_valid(rx_valid), .i_sb_rx_msg(rx_msg),
        .i_sb_rx_data(rx_data), .o_busy(busy), .o_done(done), .o_fail(fail),
        .o_neg_protocol(neg_proto), .o_neg_format(neg_fmt)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: activity flags plus a result code (0 none, 1 agreed, 2 failed).
    bit         m_send, m_wait, m_eval, m_cap, got;
    int         m_res, m_waited;
    logic [6:0] m_loc, m_rem;

    function automatic bit agree(input logic [6:0] l, input logic [6:0] r);
        return (l[2:0] == r[2:0]) && (l[2:0] inside {3'b000, 3'b011, 3'b111}) &&
               (l[6:3] == 4'd1) && (r[6:3] == 4'd1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_send = 0; m_wait = 0; m_eval = 0; m_cap = 0; m_res = 0; m_waited = 0;
            m_loc = '0; m_rem = '0;
        end else begin
            got = (m_send || m_wait) && rx_valid && (rx_msg == 5'd0) && !m_cap;
            if (m_eval) begin
                m_eval = 0;
                m_res  = agree(m_loc, m_rem) ? 1 : 2;
            end else if (m_res != 0) begin
                if (clear) begin m_res = 0; m_cap = 0; end
            end else if (m_send) begin
                if (ready) begin
                    m_send = 0;
                    if (m_cap || got) m_eval = 1;
                    else begin m_wait = 1; m_waited = 0; end
                end
            end else if (m_wait) begin
                if (m_cap || got) begin m_wait = 0; m_eval = 1; end
                else if (m_waited == T - 1) begin m_wait = 0; m_res = 2; end
                else m_waited++;
            end else if (start) begin
                m_send = 1;
                m_loc  = {lfmt, lproto};
            end
            if (got) begin m_cap = 1; m_rem = rx_data[6:0]; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_tx_valid", tx_valid, m_send);
            chk("m_tx_msg", tx_msg, 5'd0);
            chk("m_tx_data", tx_data, m_send ? {9'd0, m_loc} : 16'd0);
            chk("m_busy", busy, m_send || m_wait || m_eval);
            chk("m_done", done, m_res == 1);
            chk("m_fail", fail, m_res == 2);
            chk("m_neg_proto", neg_proto, (m_res == 1) ? m_loc[2:0] : 3'd0);
            chk("m_neg_fmt", neg_fmt, (m_res == 1) ? m_loc[6:3] : 4'd0);
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_txv"}, tx_valid, 0);
        chk({tag, "_txd"}, tx_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_fail"}, fail, 0);
        chk({tag, "_neg"}, {neg_fmt, neg_proto}, 0);
    endtask

    task automatic pulse_start(input logic [2:0] p, input logic [3:0] f);
        lproto = p; lfmt = f; start = 1; step(); start = 0;
    endtask

    task automatic send_rx(input logic [4:0] msg, input logic [15:0] d);
        rx_valid = 1; rx_msg = msg; rx_data = d; step(); rx_valid = 0;
    endtask

    task automatic do_clear;
        clear = 1; step(); clear = 0;
    endtask

    initial begin
        rst = 1; start = 0; clear = 0; ready = 0; rx_valid = 0; rx_msg = 0; rx_data = 0;
        lproto = 0; lfmt = 0;
        step(); chk_en = 1; step(); rst = 0;
        chk_zero("reset");

        // 1: PCIe/RAW, remote cap in WAIT_CAP
        ready = 1;
        pulse_start(3'b000, 4'b0001);
        chk("t1_txv", tx_valid, 1); chk("t1_txd", tx_data, 16'h0008);
        step(2);
        send_rx(5'd0, 16'h0008);
        chk("t1_eval_busy", busy, 1);
        step();
        chk("t1_done", done, 1); chk("t1_fail", fail, 0);
        chk("t1_nproto", neg_proto, 3'b000); chk("t1_nfmt", neg_fmt, 4'b0001);
        do_clear();

        // 2: cap arrives while tx stalled; EVAL directly after handshake
        ready = 0;
        pulse_start(3'b011, 4'b0001);
        send_rx(5'd0, 16'h000B);
        for (int i = 0; i < 4; i++) begin
            chk("t2_stall_txd", tx_data, 16'h000B); step();
        end
        chk("t2_stall_txv", tx_valid, 1);
        ready = 1; step(); ready = 0;
        chk("t2_h1_done", done, 0); chk("t2_h1_busy", busy, 1);
        step();
        chk("t2_h2_done", done, 1); chk("t2_nproto", neg_proto, 3'b011);
        do_clear();

        // 3: timeout, then cap in the expiry cycle
        ready = 1;
        pulse_start(3'b000, 4'b0001); step();
        for (int i = 1; i < T; i++) begin step(); chk("t3_early_fail", fail, 0); end
        step(); chk("t3_timeout_fail", fail, 1); chk("t3_timeout_neg", neg_fmt, 0);
        do_clear();
        pulse_start(3'b000, 4'b0001); step();
        step(T - 1);
        send_rx(5'd0, 16'h0008);
        chk("t3_expiry_fail", fail, 0);
        step(); chk("t3_expiry_done", done, 1);
        do_clear();

        // 4: protocol mismatch and format mismatch
        pulse_start(3'b111, 4'b0001); send_rx(5'd0, 16'h0008); step(2);
        chk("t4a_fail", fail, 1); chk("t4a_neg", {neg_fmt, neg_proto}, 0);
        do_clear();
        pulse_start(3'b000, 4'b0001); send_rx(5'd0, 16'h0010); step(2);
        chk("t4b_fail", fail, 1); chk("t4b_done", done, 0);
        do_clear();

        // 5: non-cap message ignored, first cap wins
        pulse_start(3'b000, 4'b0001);
        send_rx(5'b10101, 16'h0007);
        send_rx(5'd0, 16'h0008);
        send_rx(5'd0, 16'h000F);
        step();
        chk("t5_done", done, 1); chk("t5_nproto", neg_proto, 3'b000);
        do_clear();
        chk_zero("t5_clear");

        // 6: reset in WAIT_CAP, reset in SEND_CAP, then a clean run
        pulse_start(3'b000, 4'b0001); step();
        rst = 1; step(); rst = 0;
        chk_zero("t6_rst_wait");
        ready = 0;
        pulse_start(3'b011, 4'b0001);
        rst = 1; step(); rst = 0;
        chk_zero("t6_rst_send");
        ready = 1;
        pulse_start(3'b011, 4'b0001);
        send_rx(5'd0, 16'hFF8B);
        step();
        chk("t6_fresh_done", done, 1); chk("t6_fresh_nproto", neg_proto, 3'b011);
        do_clear();

        // Random traffic
        begin
            logic [2:0] ptab [5];
            logic [3:0] ftab [3];
            ptab = '{3'b000, 3'b011, 3'b111, 3'b001, 3'b010};
            ftab = '{4'b0001, 4'b0001, 4'b0010};
            for (int cyc = 0; cyc < 3000; cyc++) begin
                int rate;
                rate     = ((cyc / 500) % 2 == 1) ? 40 : 4;
                rst      = ($urandom_range(0, 199) == 0);
                start    = ($urandom_range(0, 9) == 0);
                clear    = ($urandom_range(0, 7) == 0);
                ready    = $urandom_range(0, 1) == 1;
                rx_valid = ($urandom_range(0, rate - 1) == 0);
                rx_msg   = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
                rx_data  = {9'($urandom), ftab[$urandom_range(0, 2)], ptab[$urandom_range(0, 4)]};
                lproto   = ptab[$urandom_range(0, 4)];
                lfmt     = ftab[$urandom_range(0, 2)];
                step();
            end
        end
        rst = 0; start = 0; clear = 0; rx_valid = 0;
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
